// File: rtl/virtual_pin_bridge.sv
// Purpose: host-accessible virtual switches, pushbuttons, LED readback and
//          double-buffered parameter words for boards without physical I/O.
// Latency: reads return one cycle after host_read; writes take effect next cycle.
// Backpressure: none; the host may issue one read and/or one write every cycle.
//
// Ports:
//   clk_clk, reset_reset      single clock, synchronous active-high reset
//   led_in                    live LED state from the user design
//   sw_out, pb_out            virtual switches and pushbuttons
//   param_out                 live parameter words, word i at [i*PARAM_W +: PARAM_W]
//   host_addr/write/wdata     word-addressed host write port
//   host_read/rdata/rvalid    host read port, data valid one cycle after the strobe
//   irq                       LED-change interrupt (gated by irq_en)
module virtual_pin_bridge #(
  parameter int LED_W           = 64,
  parameter int SW_W            = 10,
  parameter int PB_W            = 2,
  parameter int N_PARAM         = 3,
  parameter int PARAM_W         = 32,
  parameter int PB_PULSE_CYCLES = 50000,
  parameter int AUTO_COMMIT     = 0
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic [LED_W-1:0]           led_in,
  output logic [SW_W-1:0]            sw_out,
  output logic [PB_W-1:0]            pb_out,
  output logic [N_PARAM*PARAM_W-1:0] param_out,
  input  logic [5:0]                 host_addr,
  input  logic                       host_write,
  input  logic [31:0]                host_wdata,
  input  logic                       host_read,
  output logic [31:0]                host_rdata,
  output logic                       host_rvalid,
  output logic                       irq
);

  localparam logic [31:0] PB_RELOAD = 32'(PB_PULSE_CYCLES);
  localparam logic [7:0]  N_PARAM_B = 8'(N_PARAM);

  logic [SW_W-1:0]            sw_q, sw_d;
  logic [PB_W-1:0]            pb_q, pb_d;
  logic [31:0]                pb_cnt_q, pb_cnt_d;
  logic [N_PARAM*PARAM_W-1:0] shadow_q, shadow_d;
  logic [N_PARAM*PARAM_W-1:0] live_q, live_d;
  logic [31:0]                led_hold_q, led_hold_d;
  logic [LED_W-1:0]           led_prev_q, led_prev_d;
  logic                       prev_vld_q, prev_vld_d;
  logic                       led_changed_q, led_changed_d;
  logic                       commit_pending_q, commit_pending_d;
  logic                       irq_en_q, irq_en_d;
  logic                       irq_q, irq_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       rvalid_q, rvalid_d;

  // Zero-extended view so the LED_HI half reads 0 for narrow LED buses.
  logic [63:0] led_ext;
  assign led_ext = 64'(led_in);

  logic wr_ctrl, wr_sw, wr_pb, rd_led_lo, led_set;
  logic [PB_W-1:0] pb_wdat;
  assign wr_ctrl   = host_write && (host_addr == 6'h01);
  assign wr_sw     = host_write && (host_addr == 6'h02);
  assign wr_pb     = host_write && (host_addr == 6'h03);
  assign rd_led_lo = host_read  && (host_addr == 6'h04);
  assign pb_wdat   = host_wdata[PB_W-1:0];
  // prev_vld_q masks the bogus compare against the reset value of led_prev_q.
  assign led_set   = prev_vld_q && (led_in != led_prev_q);

  always_comb begin
    sw_d             = sw_q;
    pb_d             = pb_q;
    pb_cnt_d         = pb_cnt_q;
    shadow_d         = shadow_q;
    live_d           = live_q;
    led_hold_d       = led_hold_q;
    led_prev_d       = led_in;
    prev_vld_d       = 1'b1;
    commit_pending_d = commit_pending_q;
    irq_en_d         = irq_en_q;
    irq_d            = led_changed_q & irq_en_q;
    rvalid_d         = host_read;
    rdata_d          = '0;

    if (wr_sw) sw_d = host_wdata[SW_W-1:0];

    if (PB_PULSE_CYCLES == 0) begin
      if (wr_pb) pb_d = pb_wdat;
    end else begin
      // A nonzero write reloads the shared timer; otherwise the timer runs down
      // and releases every button together when it reaches zero.
      if (wr_pb) pb_d = pb_q | pb_wdat;
      if (wr_pb && (pb_wdat != '0)) begin
        pb_cnt_d = PB_RELOAD;
      end else if (pb_cnt_q != '0) begin
        pb_cnt_d = pb_cnt_q - 32'd1;
        if (pb_cnt_q == 32'd1) pb_d = '0;
      end
    end

    for (int i = 0; i < N_PARAM; i++) begin
      if (host_write && (host_addr == 6'(16 + i))) begin
        shadow_d[i*PARAM_W +: PARAM_W] = host_wdata[PARAM_W-1:0];
        if (AUTO_COMMIT != 0) live_d[i*PARAM_W +: PARAM_W] = host_wdata[PARAM_W-1:0];
        else                  commit_pending_d = 1'b1;
      end
    end

    if (wr_ctrl) begin
      irq_en_d = host_wdata[2];
      if (host_wdata[0]) begin
        live_d           = shadow_q;
        commit_pending_d = 1'b0;
      end
    end

    // A new change wins over a coincident clear so no edge is lost.
    led_changed_d = led_set | (led_changed_q & ~(wr_ctrl & host_wdata[1]));

    // Latch the upper LED half with the lower read so a 64-bit value is coherent.
    if (rd_led_lo) led_hold_d = led_ext[63:32];

    if (host_read) begin
      case (host_addr)
        6'h00: rdata_d = {8'h02, N_PARAM_B, 14'd0, commit_pending_q, led_changed_q};
        6'h01: rdata_d = {29'd0, irq_en_q, 2'd0};
        6'h02: rdata_d = 32'(sw_q);
        6'h03: rdata_d = 32'(pb_q);
        6'h04: rdata_d = led_ext[31:0];
        6'h05: rdata_d = led_hold_q;
        default: begin
          for (int i = 0; i < N_PARAM; i++) begin
            if (host_addr == 6'(16 + i)) rdata_d = 32'(shadow_q[i*PARAM_W +: PARAM_W]);
            if (host_addr == 6'(32 + i)) rdata_d = 32'(live_q[i*PARAM_W +: PARAM_W]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sw_q             <= '0;
      pb_q             <= '0;
      pb_cnt_q         <= '0;
      shadow_q         <= '0;
      live_q           <= '0;
      led_hold_q       <= '0;
      led_prev_q       <= '0;
      prev_vld_q       <= 1'b0;
      led_changed_q    <= 1'b0;
      commit_pending_q <= 1'b0;
      irq_en_q         <= 1'b0;
      irq_q            <= 1'b0;
      rdata_q          <= '0;
      rvalid_q         <= 1'b0;
    end else begin
      sw_q             <= sw_d;
      pb_q             <= pb_d;
      pb_cnt_q         <= pb_cnt_d;
      shadow_q         <= shadow_d;
      live_q           <= live_d;
      led_hold_q       <= led_hold_d;
      led_prev_q       <= led_prev_d;
      prev_vld_q       <= prev_vld_d;
      led_changed_q    <= led_changed_d;
      commit_pending_q <= commit_pending_d;
      irq_en_q         <= irq_en_d;
      irq_q            <= irq_d;
      rdata_q          <= rdata_d;
      rvalid_q         <= rvalid_d;
    end
  end

  assign sw_out      = sw_q;
  assign pb_out      = pb_q;
  assign param_out   = live_q;
  assign host_rdata  = rdata_q;
  assign host_rvalid = rvalid_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_virtual_pin_bridge.sv
// Purpose: randomized and directed stimulus for virtual_pin_bridge with a
//          queue scoreboard for reads and a per-cycle check of the outputs.
// Latency: stimulus advances one clock per step; read responses are due one cycle later.
// Backpressure: none.
module tb_virtual_pin_bridge;

  localparam int P = 4;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [63:0] led_in = '0;
  logic [9:0]  sw_out;
  logic [1:0]  pb_out;
  logic [95:0] param_out;
  logic [5:0]  host_addr = '0;
  logic        host_write = 1'b0;
  logic [31:0] host_wdata = '0;
  logic        host_read = 1'b0;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        irq;

  always #5 clk_clk = ~clk_clk;

  virtual_pin_bridge #(
    .LED_W(64), .SW_W(10), .PB_W(2), .N_PARAM(3), .PARAM_W(32),
    .PB_PULSE_CYCLES(P), .AUTO_COMMIT(0)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .led_in(led_in),
    .sw_out(sw_out), .pb_out(pb_out), .param_out(param_out),
    .host_addr(host_addr), .host_write(host_write), .host_wdata(host_wdata),
    .host_read(host_read), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .irq(irq)
  );

  typedef struct {
    int          due;
    logic [31:0] dat;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int mcyc = 0;
  bit mon_en = 1'b0;
  logic [63:0] cur_led = '0;

  // Reference model: register contents as the host sees them after edge mcyc.
  logic [9:0]  m_sw;
  logic [1:0]  m_pb_acc;
  int          m_pb_rel;
  logic [31:0] m_shadow[3];
  logic [31:0] m_live[3];
  bit          m_pending, m_changed, m_irq_en, m_irq, m_primed;
  logic [63:0] m_led_prev;
  logic [31:0] m_hold;

  // Buttons are held until P edges after the most recent nonzero write.
  function automatic logic [1:0] pb_vis();
    return (mcyc <= m_pb_rel) ? m_pb_acc : 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      6'h00: r = {8'h02, 8'd3, 14'd0, m_pending, m_changed};
      6'h01: r = {29'd0, m_irq_en, 2'd0};
      6'h02: r = {22'd0, m_sw};
      6'h03: r = {30'd0, pb_vis()};
      6'h04: r = cur_led[31:0];
      6'h05: r = m_hold;
      6'h10, 6'h11, 6'h12: r = m_shadow[a - 6'h10];
      6'h20, 6'h21, 6'h22: r = m_live[a - 6'h20];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic m_update(input bit rst, input bit wr, input bit rd,
                          input logic [5:0] a, input logic [31:0] wd);
    bit old_changed, old_irq_en, clr;
    if (rst) begin
      m_sw = '0; m_pb_acc = '0; m_pb_rel = 0;
      for (int i = 0; i < 3; i++) begin m_shadow[i] = '0; m_live[i] = '0; end
      m_pending = 0; m_changed = 0; m_irq_en = 0; m_irq = 0; m_primed = 0;
      m_led_prev = '0; m_hold = '0;
    end else begin
      old_changed = m_changed;
      old_irq_en  = m_irq_en;
      clr = 1'b0;
      if (wr) begin
        if (a == 6'h02) m_sw = wd[9:0];
        if (a == 6'h03 && wd[1:0] != 2'b00) begin
          if (pb_vis() == 2'b00) m_pb_acc = 2'b00;
          m_pb_acc = m_pb_acc | wd[1:0];
          m_pb_rel = mcyc + P;
        end
        if (a >= 6'h10 && a <= 6'h12) begin
          m_shadow[a - 6'h10] = wd;
          m_pending = 1'b1;
        end
        if (a == 6'h01) begin
          m_irq_en = wd[2];
          clr = wd[1];
          if (wd[0]) begin
            m_live = m_shadow;
            m_pending = 1'b0;
          end
        end
      end
      if (rd && a == 6'h04) m_hold = cur_led[63:32];
      m_changed  = (m_primed && cur_led != m_led_prev) || (m_changed && !clr);
      m_irq      = old_changed && old_irq_en;
      m_led_prev = cur_led;
      m_primed   = 1'b1;
    end
    mcyc++;
  endtask

  // One clock of stimulus; the read's expected data is taken from the model
  // before the same-cycle write is applied.
  task automatic step(input bit rst, input bit wr, input bit rd,
                      input logic [5:0] a, input logic [31:0] wd);
    reset_reset = rst;
    host_write  = wr;
    host_read   = rd;
    host_addr   = a;
    host_wdata  = wd;
    led_in      = cur_led;
    if (rd && !rst) exp_q.push_back('{due: mcyc + 1, dat: model_read(a)});
    @(posedge clk_clk);
    m_update(rst, wr, rd, a, wd);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 6'h00, 32'd0);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, mcyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data and
  // compares the live outputs against the model every cycle.
  always @(negedge clk_clk) begin
    rd_exp_t e;
    if (mon_en) begin
      if (host_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_cycle", 128'(mcyc), 128'(e.due));
          chk("rdata", 128'(host_rdata), 128'(e.dat));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= mcyc) begin
        chk("rvalid_missing", 128'd0, 128'd1);
        e = exp_q.pop_front();
      end
      chk("sw_out", 128'(sw_out), 128'(m_sw));
      chk("pb_out", 128'(pb_out), 128'(pb_vis()));
      chk("param_out", 128'(param_out), 128'({m_live[2], m_live[1], m_live[0]}));
      chk("irq", 128'(irq), 128'(m_irq));
    end
  end

  logic [5:0] atab [14] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h10,
                            6'h11, 6'h12, 6'h13, 6'h20, 6'h21, 6'h22, 6'h3F};

  initial begin
    logic [5:0]  ra;
    logic [31:0] rw;
    step(1, 0, 0, 6'h00, 32'd0);
    mon_en = 1'b1;
    step(1, 0, 0, 6'h00, 32'd0);

    // Reset state and identification word.
    step(0, 0, 1, 6'h00, 32'd0);
    idle(1);

    // Shadow writes, pending flag, then commit.
    step(0, 1, 0, 6'h10, 32'hAAAA_0001);
    step(0, 1, 0, 6'h12, 32'h0000_0005);
    step(0, 0, 1, 6'h00, 32'd0);
    step(0, 1, 0, 6'h01, 32'd1);
    step(0, 0, 1, 6'h00, 32'd0);
    step(0, 0, 1, 6'h20, 32'd0);
    step(0, 0, 1, 6'h21, 32'd0);
    step(0, 0, 1, 6'h22, 32'd0);
    step(0, 1, 0, 6'h01, 32'd1);   // commit with nothing pending
    idle(1);

    // Pushbutton pulse and extension by a second press.
    step(0, 1, 0, 6'h03, 32'd1);
    idle(1);
    step(0, 1, 0, 6'h03, 32'd2);
    step(0, 1, 0, 6'h03, 32'd0);   // zero write must not reload
    idle(6);
    step(0, 1, 0, 6'h03, 32'd1);
    idle(6);

    // LED change interrupt, coincident set/clear, clear alone.
    step(0, 1, 0, 6'h01, 32'd4);
    cur_led = 64'h1_0000_0000;
    idle(3);
    step(0, 0, 1, 6'h00, 32'd0);
    cur_led = 64'h3_0000_0000;
    step(0, 1, 0, 6'h01, 32'd6);
    idle(1);
    step(0, 1, 0, 6'h01, 32'd6);
    idle(2);
    step(0, 0, 1, 6'h01, 32'd0);

    // Coherent 64-bit LED read.
    cur_led = 64'h1111_1111_2222_2222;
    idle(1);
    step(0, 0, 1, 6'h04, 32'd0);
    cur_led = 64'h3333_3333_4444_4444;
    step(0, 0, 1, 6'h05, 32'd0);

    // Read sees pre-write value; unmapped addresses.
    step(0, 1, 1, 6'h02, 32'h0000_03FF);
    step(0, 0, 1, 6'h02, 32'd0);
    step(0, 1, 0, 6'h3F, 32'hFFFF_FFFF);
    step(0, 0, 1, 6'h3F, 32'd0);
    step(0, 0, 1, 6'h13, 32'd0);
    step(0, 1, 1, 6'h02, 32'hFFFF_FFFF);   // truncation to 10 bits

    // Reset mid-pulse with a pending commit and a nonzero LED bus.
    step(0, 1, 0, 6'h11, 32'h1234_5678);
    step(0, 1, 0, 6'h03, 32'd3);
    idle(1);
    step(1, 0, 0, 6'h00, 32'd0);
    idle(1);
    step(0, 0, 1, 6'h00, 32'd0);
    step(0, 1, 0, 6'h01, 32'd1);
    idle(6);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) cur_led = {$urandom, $urandom};
        else cur_led = cur_led ^ (64'd1 << $urandom_range(0, 63));
      end
      ra = atab[$urandom_range(0, 13)];
      rw = $urandom;
      if (ra == 6'h03 && $urandom_range(0, 3) == 0) rw = 32'd0;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 0, ra, rw);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
